bwm_mac: RTL and testbench
==========================

BWM_MAC -- requirements
Module: bwm_mac

Interface
REQ-001 Parameter BW, default 8, operand width (signed two's complement, BW >= 3) SHALL be provided.
REQ-002 Parameter ACC_W, default 20, accumulator width (ACC_W >= 2*BW) SHALL be provided.
REQ-003 Parameter LEN, default 4, products per dot product (LEN >= 1) SHALL be provided.
REQ-004 One clock and an asynchronous, active-high reset SHALL be used: clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block accepts operand pair.
REQ-008 x  input  BW  signed multiplicand.
REQ-009 y  input  BW  signed multiplier.
REQ-010 out_valid  output  1  dot-product result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 acc  output  ACC_W  signed dot-product result.
REQ-013 ovf  output  1  signed overflow occurred in the current dot product.

Function
REQ-014 Pair transfer SHALL occur only on a rising edge with in_valid=1 and in_ready=1; x/y SHALL be captured into stage-1 registers (op_x, op_y, op_v, op_last).
REQ-015 The product SHALL come from a bwm instance (parameter BW) fed by op_x/op_y; its 2*BW-1-bit result SHALL be sign-extended to ACC_W.
REQ-016 Corner case: when op_x and op_y both equal -2^(BW-1), the product SHALL be forced to +2^(2*BW-2) (the bwm result wraps there).
REQ-017 Stage 2: on op_v=1, acc SHALL load product if it is the first pair of the dot product, else acc + product.
REQ-018 FSM states SHALL be ACC, WAIT, HOLD; reset state ACC.
REQ-019 ACC: in_ready=1; pair counter increments per transfer; the LEN-th transfer sets op_last, clears the counter and moves to WAIT.
REQ-020 WAIT: in_ready=0, out_valid=0; last product accumulates; unconditionally -> HOLD next cycle.
REQ-021 HOLD: out_valid=1, in_ready=0; acc and ovf stable; out_ready=1 -> ACC next cycle.
REQ-022 Latency: LEN-th transfer at edge N -> out_valid=1 in cycle after edge N+2.
REQ-023 in_valid gaps in ACC SHALL not affect the result; counter holds.
REQ-024 ovf SHALL be sticky within a dot product, set when the signed ACC_W sum overflows, cleared at the first pair of the next dot product.
REQ-025 LEN=1: every transfer SHALL go ACC->WAIT->HOLD.

Reset
REQ-026 rst=1 SHALL immediately force state ACC, counter 0, op_v 0, acc 0, ovf 0, out_valid 0; in_ready SHALL be 1 after release.
REQ-027 Reset mid-dot-product SHALL discard partial sums; the next transfer starts a new dot product.

Configuration
REQ-028 Macro BWM_MAC_SAT_EN defined: on overflow, acc SHALL saturate to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and remain clamped for the rest of that dot product (subsequent terms added to the clamped value, re-clamped); ovf=1.
REQ-029 Macro undefined: acc SHALL wrap modulo 2^ACC_W; ovf still reported.

Verification (BW=8, LEN=4)
REQ-030 ACC_W=20; pairs (3,4),(-2,5),(7,-1),(-6,-6) -> acc=31, ovf=0, out_valid 2 edges after 4th transfer.
REQ-031 ACC_W=20; four pairs (-128,-128) -> acc=65536, ovf=0.
REQ-032 ACC_W=16; four pairs (-128,-128) -> with BWM_MAC_SAT_EN acc=32767 ovf=1; without, acc=0 ovf=1.
REQ-033 out_ready=0 for 5 cycles in HOLD -> acc/out_valid held, in_ready=0; out_ready=1 -> in_ready=1 next cycle; next dot product (1,1)x4 -> acc=4.
REQ-034 rst pulse after 2 transfers -> all outputs 0; then (1,2)x4 -> acc=8.
REQ-035 in_valid toggled 1/0 each cycle with (5,-3)x4 -> acc=-60, result identical to back-to-back.

Source files
------------

// File: rtl/bwm_mac.sv
// bwm_mac: streaming signed dot-product engine.
//   Operand pairs (x, y) are accepted with a valid/ready handshake. Each
//   product comes from a Baugh-Wooley array multiplier (bwm), is
//   sign-extended and accumulated. After LEN products the result is
//   presented on acc/ovf with out_valid until the consumer takes it.
// Build option:
//   BWM_MAC_SAT_EN defined   -> accumulator saturates on signed overflow.
//   BWM_MAC_SAT_EN undefined -> accumulator wraps modulo 2^ACC_W.
//   ovf reports overflow in both builds.

// Baugh-Wooley signed multiplier. The result is truncated to 2*BW-1 bits,
// so (-2^(BW-1)) * (-2^(BW-1)) wraps to -2^(2*BW-2). The caller fixes
// that single case.
module bwm #(
  parameter int BW = 8
) (
  input  logic [BW-1:0]   i_a,
  input  logic [BW-1:0]   i_b,
  output logic [2*BW-2:0] o_p
);
  localparam int PW = 2*BW-1;

  logic [PW-1:0] w_row;
  logic [PW-1:0] w_sum;
  logic          w_bit;

  // Sum the partial-product rows. Cross terms involving exactly one sign bit
  // are inverted, and a constant 2^BW corrects for the inversions.
  always_comb begin
    w_sum = {{(PW-1){1'b0}}, 1'b1} << BW;
    w_row = '0;
    w_bit = 1'b0;
    for (int i = 0; i < BW; i++) begin
      w_row = '0;
      for (int j = 0; j < BW; j++) begin
        w_bit = i_a[i] & i_b[j];
        w_row[i+j] = ((i == BW-1) != (j == BW-1)) ? ~w_bit : w_bit;
      end
      w_sum = w_sum + w_row;
    end
    o_p = w_sum;
  end
endmodule

module bwm_mac #(
  parameter int BW    = 8,
  parameter int ACC_W = 20,
  parameter int LEN   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [BW-1:0]    x,
  input  logic signed [BW-1:0]    y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc,
  output logic                    ovf
);
  localparam int PW = 2*BW-1;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [BW-1:0]    OP_MIN = {1'b1, {(BW-1){1'b0}}};
  localparam logic [ACC_W-1:0] MIN_SQ = {{(ACC_W-1){1'b0}}, 1'b1} << (2*BW-2);
`ifdef BWM_MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_cnt_last;
  logic [CW-1:0]    r_cnt;

  logic [BW-1:0]    r_op_x;
  logic [BW-1:0]    r_op_y;
  logic             r_op_v;
  logic             r_op_last;
  logic             r_new_dp;

  logic [PW-1:0]    w_prod_raw;
  logic [ACC_W-1:0] w_prod;
  logic [ACC_W:0]   w_sum;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_acc_nxt;

  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_out_valid;

  assign w_cnt_last = (r_cnt == CW'(LEN-1));
  assign w_xfer     = in_valid & w_in_ready;
  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign acc        = r_acc;
  assign ovf        = r_ovf;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACC;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      ACC: begin
        w_in_ready = 1'b1;
        if (in_valid && w_cnt_last) begin
          w_next = WAIT;
        end else begin
          w_next = ACC;
        end
      end
      WAIT: begin
        w_next = HOLD;
      end
      HOLD: begin
        if (r_out_valid && out_ready) begin
          w_next = ACC;
        end else begin
          w_next = HOLD;
        end
      end
      default: begin
        w_next = ACC;
      end
    endcase
  end

  // Stage 1: capture the accepted pair and count pairs in this dot product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op_x    <= '0;
      r_op_y    <= '0;
      r_op_v    <= 1'b0;
      r_op_last <= 1'b0;
    end else begin
      r_op_v <= w_xfer;
      if (w_xfer) begin
        r_op_x    <= x;
        r_op_y    <= y;
        r_op_last <= w_cnt_last;
        r_cnt     <= w_cnt_last ? '0 : (r_cnt + CW'(1));
      end
    end
  end

  bwm #(.BW(BW)) u_bwm (
    .i_a (r_op_x),
    .i_b (r_op_y),
    .o_p (w_prod_raw)
  );

  // Sign-extend the product; min*min is the one case the multiplier wraps.
  always_comb begin
    if ((r_op_x == OP_MIN) && (r_op_y == OP_MIN)) begin
      w_prod = MIN_SQ;
    end else begin
      w_prod = {{(ACC_W-PW){w_prod_raw[PW-1]}}, w_prod_raw};
    end
  end

  // Add the next term with signed overflow detection, then clamp or wrap.
  always_comb begin
    w_sum     = {r_acc[ACC_W-1], r_acc} + {w_prod[ACC_W-1], w_prod};
    w_add_ovf = (w_sum[ACC_W] != w_sum[ACC_W-1]);
`ifdef BWM_MAC_SAT_EN
    if (w_add_ovf) begin
      w_acc_nxt = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_acc_nxt = w_sum[ACC_W-1:0];
    end
`else
    w_acc_nxt = w_sum[ACC_W-1:0];
`endif
  end

  // Stage 2: the first term loads the accumulator and clears ovf, later
  // terms add in; r_new_dp remembers whether the next term starts afresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_new_dp <= 1'b1;
    end else if (r_op_v) begin
      r_new_dp <= r_op_last;
      if (r_new_dp) begin
        r_acc <= w_prod;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_acc_nxt;
        r_ovf <= r_ovf | w_add_ovf;
      end
    end
  end

  // Result valid: raised one cycle into HOLD (after the final sum has
  // settled in acc), dropped on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (r_state == HOLD) && !(r_out_valid && out_ready);
    end
  end
endmodule

// File: tb/tb_bwm_mac.sv
// Directed bench for bwm_mac (BW=8, LEN=4). Instance a uses ACC_W=20,
// instance b uses ACC_W=16 to exercise overflow; expectations for b
// depend on BWM_MAC_SAT_EN.
module tb_bwm_mac;
  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic signed [7:0] x;
  logic signed [7:0] y;

  logic               in_ready_a, out_valid_a, ovf_a;
  logic signed [19:0] acc_a;
  logic               in_ready_b, out_valid_b, ovf_b;
  logic signed [15:0] acc_b;

  int checks   = 0;
  int failures = 0;

`ifdef BWM_MAC_SAT_EN
  localparam int EXP_MINSQ_B = 32767;
  localparam int EXP_NEG_B   = -32768;
`else
  localparam int EXP_MINSQ_B = 0;
  localparam int EXP_NEG_B   = 512;
`endif

  bwm_mac #(.BW(8), .ACC_W(20), .LEN(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .x(x), .y(y), .out_valid(out_valid_a), .out_ready(out_ready),
    .acc(acc_a), .ovf(ovf_a)
  );

  bwm_mac #(.BW(8), .ACC_W(16), .LEN(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .x(x), .y(y), .out_valid(out_valid_b), .out_ready(out_ready),
    .acc(acc_b), .ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One transfer; optional idle cycle afterwards with junk on x/y.
  task automatic push(input logic signed [7:0] xv, input logic signed [7:0] yv,
                      input bit gap);
    check("in_ready_pre_xfer", in_ready_a, 1);
    x        = xv;
    y        = yv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x        = 8'($urandom);
    y        = 8'($urandom);
    if (gap) tick();
  endtask

  // Called right after the LEN-th transfer edge N (+1ns).
  task automatic expect_result(input string tag, input int ea, input int oa,
                               input int eb, input int ob, input bit chk_b);
    check({tag, "_ready_N"}, in_ready_a, 0);
    check({tag, "_valid_N"}, out_valid_a, 0);
    tick();
    check({tag, "_valid_N1"}, out_valid_a, 0);
    check({tag, "_ready_N1"}, in_ready_a, 0);
    tick();
    check({tag, "_valid_N2"}, out_valid_a, 1);
    check({tag, "_acc_a"}, acc_a, ea);
    check({tag, "_ovf_a"}, ovf_a, oa);
    if (chk_b) begin
      check({tag, "_valid_b"}, out_valid_b, 1);
      check({tag, "_acc_b"}, acc_b, eb);
      check({tag, "_ovf_b"}, ovf_b, ob);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", in_ready_a, 1);
    check("release_out_valid", out_valid_a, 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = 8'sd0;
    y         = 8'sd0;
    #2;
    check("rst_acc", acc_a, 0);
    check("rst_ovf", ovf_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_acc_b", acc_b, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready_a, 1);

    // Mixed-sign dot product: 12 - 10 - 7 + 36 = 31
    push(8'sd3, 8'sd4, 1'b0);
    push(-8'sd2, 8'sd5, 1'b0);
    push(8'sd7, -8'sd1, 1'b0);
    push(-8'sd6, -8'sd6, 1'b0);
    expect_result("mixed", 31, 0, 31, 0, 1'b1);
    release_out();

    // min*min four times: 4 * 16384 = 65536; overflows a 16-bit acc
    for (int i = 0; i < 4; i++) push(-8'sd128, -8'sd128, 1'b0);
    expect_result("minsq", 65536, 0, EXP_MINSQ_B, 1, 1'b1);

    // Consumer stalls for five cycles: result must hold
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", out_valid_a, 1);
      check("hold_acc", acc_a, 65536);
      check("hold_in_ready", in_ready_a, 0);
      check("hold_acc_b", acc_b, EXP_MINSQ_B);
    end
    release_out();

    // Next product after overflow: ovf must be cleared
    for (int i = 0; i < 4; i++) push(8'sd1, 8'sd1, 1'b0);
    expect_result("ones", 4, 0, 4, 0, 1'b1);
    release_out();

    // Reset after two transfers discards the partial sum
    push(8'sd9, 8'sd9, 1'b0);
    push(8'sd9, 8'sd9, 1'b0);
    check("partial_acc", acc_a, 81);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_acc", acc_a, 0);
    check("mid_rst_ovf", ovf_a, 0);
    check("mid_rst_out_valid", out_valid_a, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready_a, 1);
    for (int i = 0; i < 4; i++) push(8'sd1, 8'sd2, 1'b0);
    expect_result("after_rst", 8, 0, 8, 0, 1'b1);
    release_out();

    // Gapped input: 4 * (-15) = -60
    push(8'sd5, -8'sd3, 1'b1);
    push(8'sd5, -8'sd3, 1'b1);
    push(8'sd5, -8'sd3, 1'b1);
    push(8'sd5, -8'sd3, 1'b0);
    expect_result("gapped", -60, 0, -60, 0, 1'b1);
    release_out();

    // Same pairs back-to-back
    for (int i = 0; i < 4; i++) push(8'sd5, -8'sd3, 1'b0);
    expect_result("b2b", -60, 0, -60, 0, 1'b1);
    release_out();

    // Negative overflow: 4 * (-16256) = -65024
    for (int i = 0; i < 4; i++) push(-8'sd128, 8'sd127, 1'b0);
    expect_result("negovf", -65024, 0, EXP_NEG_B, 1, 1'b1);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
